i2c_master_ctrl: RTL and testbench

- Synthesizable single-master I2C controller that sequences byte-addressed write and random-read transactions to the bus slave model (7-bit device ID, 8-bit inner address, 256×8 memory).
- Accepts one command at a time on a valid/ready interface.
- Generates SCL from the system clock, drives and releases SDA, checks slave ACKs, and returns read data plus an error flag.
- Sits between the testbench or host logic and the shared scl/sda bus.

---
 rtl/i2c_master_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// Single-master I2C controller: byte-addressed write and random read, open-drain sda.
// Latency: write 114, read 154, NACK at first byte 42 quarters (x CLK_DIV clk) + 1 clk to rsp_valid.
// Backpressure: cmd_ready is high only in IDLE; commands presented while busy are ignored.
module i2c_master_ctrl #(
   parameter int unsigned CLK_DIV = 25,
   parameter logic [6:0]  DEF_DEV = 7'b1000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rw,
   input  logic [6:0] cmd_dev,
   input  logic [7:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_nack,
   output logic       busy,
   output logic [6:0] dbg_dev,
   output logic       scl,
   inout  wire        sda
);
   localparam int QW = $clog2(CLK_DIV);

   typedef enum logic [3:0] {IDLE, START, BIT, ACK, RSTART, RBIT, MNACK, STOP, RESP} state_t;

   state_t        state, state_n;
   logic [QW-1:0] qcnt;
   logic [1:0]    phase, phase_n;
   logic [2:0]    bitcnt, bitcnt_n;
   logic [1:0]    bidx, bidx_n;
   logic          nack, nack_n;
   logic [7:0]    rx, rx_n;
   logic [7:0]    rdata, rdata_n;
   logic          scl_n, sda_oe, sda_oe_n;
   logic          rw_q;
   logic [6:0]    dev_q;
   logic [7:0]    addr_q, wdata_q;
   logic [7:0]    tx_byte;
   logic          tick, accept, adv, sda_in;

   assign sda       = sda_oe ? 1'b0 : 1'bz;
   assign sda_in    = sda;
   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign rsp_valid = (state == RESP);
   assign rsp_nack  = nack;
   assign rsp_rdata = rdata;
   assign dbg_dev   = dev_q;
   assign tick      = (qcnt == QW'(CLK_DIV - 1));
   assign accept    = cmd_valid && (state == IDLE);
   // a phase boundary: either a new command starts or a quarter expires mid-transaction
   assign adv       = accept || (tick && state != IDLE && state != RESP);

   // byte currently being shifted out, selected by the byte index
   always_comb begin
      tx_byte = {dev_q, 1'b0};
      case (bidx)
         2'd0:    tx_byte = {dev_q, 1'b0};
         2'd1:    tx_byte = addr_q;
         default: tx_byte = rw_q ? {dev_q, 1'b1} : wdata_q;
      endcase
   end

   // next state, bit/byte sequencing, and bus levels for the phase being entered
   always_comb begin
      state_n  = state;
      phase_n  = phase;
      bitcnt_n = bitcnt;
      bidx_n   = bidx;
      nack_n   = nack;
      rx_n     = rx;
      rdata_n  = rdata;
      scl_n    = scl;
      sda_oe_n = sda_oe;
      case (state)
         IDLE: if (cmd_valid) begin
            state_n = START;
            phase_n = 2'd0;
            bidx_n  = 2'd0;
            nack_n  = 1'b0;
         end
         RESP: state_n = IDLE;
         default: if (tick) begin
            phase_n = phase + 2'd1;
            if (state == START && phase == 2'd1) begin
               state_n  = BIT;
               phase_n  = 2'd0;
               bitcnt_n = 3'd7;
            end else if (phase == 2'd3) begin
               case (state)
                  BIT: if (bitcnt == 3'd0) state_n = ACK;
                       else bitcnt_n = bitcnt - 3'd1;
                  ACK: begin
                     bitcnt_n = 3'd7;
                     if (sda_in) begin
                        nack_n  = 1'b1;
                        state_n = STOP;
                     end else if (bidx == 2'd0) begin
                        state_n = BIT;
                        bidx_n  = 2'd1;
                     end else if (bidx == 2'd1) begin
                        state_n = rw_q ? RSTART : BIT;
                        bidx_n  = 2'd2;
                     end else begin
                        state_n = rw_q ? RBIT : STOP;
                     end
                  end
                  RBIT: begin
                     rx_n = {rx[6:0], sda_in};
                     if (bitcnt == 3'd0) state_n = MNACK;
                     else bitcnt_n = bitcnt - 3'd1;
                  end
                  MNACK:  state_n = STOP;
                  RSTART: begin
                     state_n  = BIT;
                     bitcnt_n = 3'd7;
                  end
                  STOP: begin
                     state_n = RESP;
                     if (rw_q && !nack) rdata_n = rx;
                  end
                  default: state_n = IDLE;
               endcase
            end
         end
      endcase
      if (adv) begin
         case (state_n)
            START: if (phase_n == 2'd0) begin scl_n = 1'b1; sda_oe_n = 1'b0; end
                   else sda_oe_n = 1'b1;
            BIT: case (phase_n)
               2'd0:    scl_n = 1'b0;
               2'd1:    sda_oe_n = ~tx_byte[bitcnt];
               2'd2:    scl_n = 1'b1;
               default: ;
            endcase
            ACK, RBIT, MNACK: case (phase_n)
               2'd0:    scl_n = 1'b0;
               2'd1:    sda_oe_n = 1'b0;
               2'd2:    scl_n = 1'b1;
               default: ;
            endcase
            RSTART: case (phase_n)
               2'd0:    begin scl_n = 1'b0; sda_oe_n = 1'b0; end
               2'd1:    sda_oe_n = 1'b0;
               2'd2:    scl_n = 1'b1;
               default: sda_oe_n = 1'b1;
            endcase
            STOP: case (phase_n)
               2'd0:    scl_n = 1'b0;
               2'd1:    sda_oe_n = 1'b1;
               2'd2:    scl_n = 1'b1;
               default: sda_oe_n = 1'b0;
            endcase
            default: begin scl_n = 1'b1; sda_oe_n = 1'b0; end
         endcase
      end
   end

   // quarter-period counter, idle outside bus activity
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                     qcnt <= '0;
      else if (state == IDLE || state == RESP || tick) qcnt <= '0;
      else                                            qcnt <= qcnt + QW'(1);
   end

   // state, datapath and bus registers; command fields latched on acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         phase   <= 2'd0;
         bitcnt  <= 3'd0;
         bidx    <= 2'd0;
         nack    <= 1'b0;
         rx      <= 8'd0;
         rdata   <= 8'd0;
         scl     <= 1'b1;
         sda_oe  <= 1'b0;
         rw_q    <= 1'b0;
         dev_q   <= DEF_DEV;
         addr_q  <= 8'd0;
         wdata_q <= 8'd0;
      end else begin
         state  <= state_n;
         phase  <= phase_n;
         bitcnt <= bitcnt_n;
         bidx   <= bidx_n;
         nack   <= nack_n;
         rx     <= rx_n;
         rdata  <= rdata_n;
         scl    <= scl_n;
         sda_oe <= sda_oe_n;
         if (accept) begin
            rw_q    <= cmd_rw;
            dev_q   <= cmd_dev;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
         end
      end
   end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: behavioural I2C slave on the bus, array-based memory model.
// Latency: checks acceptance-to-rsp_valid cycle counts derived from quarter counts.
// Backpressure: exercises ignored commands while busy and back-to-back issue.
module tb_i2c_master_ctrl;
   localparam int         CD     = 8;
   localparam logic [6:0] SLV_ID = 7'h40;
   localparam logic [6:0] DEFDEV = 7'h5A;

   logic       clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, cmd_rw = 1'b0;
   logic [6:0] cmd_dev = 7'd0;
   logic [7:0] cmd_addr = 8'd0, cmd_wdata = 8'd0;
   logic       cmd_ready, rsp_valid, rsp_nack, busy, scl;
   logic [7:0] rsp_rdata;
   logic [6:0] dbg_dev;
   wire        sda;

   pullup (sda);

   i2c_master_ctrl #(.CLK_DIV(CD), .DEF_DEV(DEFDEV)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_rw(cmd_rw), .cmd_dev(cmd_dev), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .busy(busy),
      .dbg_dev(dbg_dev), .scl(scl), .sda(sda)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_byte(input int i);
      return 8'(i * 37 + 'h5C);
   endfunction

   // ---------------- behavioural slave: ID 0x40, 256x8 memory, 72-unit output delay
   logic [7:0] slv_mem [256];
   logic       slv_want = 1'b0, slv_oe = 1'b0;
   logic [7:0] s_sh = 8'd0, s_ptr = 8'd0;
   logic       s_rdpend = 1'b0, s_mack = 1'b0, p_scl = 1'b1, p_sda = 1'b1;
   int         s_mode = 0, s_bit = 0, s_byte = 0, stop_cnt = 0;

   assign sda = slv_oe ? 1'b0 : 1'bz;

   initial forever begin
      @(slv_want);
      #72;
      slv_oe = slv_want;
   end

   initial begin
      for (int i = 0; i < 256; i++) slv_mem[i] = init_byte(i);
      forever begin
         @(scl or sda);
         if (p_scl === 1'b1 && scl === 1'b1 && p_sda === 1'b1 && sda === 1'b0) begin
            s_mode = 1; s_bit = 0; s_byte = 0; s_rdpend = 1'b0; s_mack = 1'b0; slv_want = 1'b0;
         end else if (p_scl === 1'b1 && scl === 1'b1 && p_sda === 1'b0 && sda === 1'b1) begin
            s_mode = 0; slv_want = 1'b0; stop_cnt++;
         end else if (p_scl === 1'b0 && scl === 1'b1) begin
            if (s_mode == 1 && s_bit < 8) begin s_sh = {s_sh[6:0], sda}; s_bit++; end
            else if (s_mode == 2 && s_bit == 8) s_mack = sda;
         end else if (p_scl === 1'b1 && scl === 1'b0) begin
            if (s_mode == 1) begin
               if (s_bit == 8) begin
                  s_bit = 9;
                  if (s_byte == 0) begin
                     if (s_sh[7:1] == SLV_ID) begin slv_want = 1'b1; s_rdpend = s_sh[0]; end
                     else s_mode = 3;
                  end else if (s_byte == 1) begin
                     s_ptr = s_sh; slv_want = 1'b1;
                  end else begin
                     slv_mem[s_ptr] = s_sh; s_ptr++; slv_want = 1'b1;
                  end
                  s_byte++;
               end else if (s_bit == 9) begin
                  slv_want = 1'b0; s_bit = 0;
                  if (s_rdpend) begin
                     s_mode = 2; s_sh = slv_mem[s_ptr]; s_ptr++; slv_want = ~s_sh[7];
                  end
               end
            end else if (s_mode == 2) begin
               if (s_bit == 8) begin
                  if (s_mack == 1'b0) begin
                     s_sh = slv_mem[s_ptr]; s_ptr++; s_bit = 0; slv_want = ~s_sh[7];
                  end else begin
                     s_mode = 3; slv_want = 1'b0;
                  end
               end else begin
                  s_bit++;
                  slv_want = (s_bit < 8) ? ~s_sh[7 - s_bit] : 1'b0;
               end
            end
         end
         p_scl = scl;
         p_sda = sda;
      end
   end

   // ---------------- reference model and checking
   logic [7:0] ref_mem [256];
   logic [7:0] ref_rdata = 8'd0;
   int         ref_stops = 0;
   int         n_cmp = 0, n_err = 0, last_wait = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int exp_lat(input bit rw, input bit present);
      int q;
      if (!present)  q = 2 + 9 * 4 + 4;
      else if (rw)   q = 2 + 18 * 4 + 4 + 18 * 4 + 4;
      else           q = 2 + 27 * 4 + 4;
      return q * CD + 1;
   endfunction

   task automatic mem_compare(input string tag);
      int diffs = 0;
      for (int i = 0; i < 256; i++) if (slv_mem[i] !== ref_mem[i]) diffs++;
      chk(tag, 32'(diffs), 32'd0);
   endtask

   // issue one command (called just after a negedge) and check its response
   task automatic run_cmd(input bit rw, input logic [6:0] dev, input logic [7:0] addr,
                          input logic [7:0] wdata, input bit poke);
      int  cyc, waitc;
      bit  present;
      present   = (dev == SLV_ID);
      cmd_valid = 1'b1; cmd_rw = rw; cmd_dev = dev; cmd_addr = addr; cmd_wdata = wdata;
      waitc = 0;
      while (cmd_ready !== 1'b1 && waitc < 1000) begin @(negedge clk); waitc++; end
      last_wait = waitc;
      chk("accept", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      cyc = 1;
      chk("busy", 32'(busy), 32'd1);
      chk("dbg_dev", 32'(dbg_dev), 32'(dev));
      while (rsp_valid !== 1'b1 && cyc < 200 * CD) begin
         if (poke && cyc == 40) begin
            cmd_valid = 1'b1; cmd_rw = ~rw; cmd_dev = 7'($urandom);
            cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
            chk("rdy_while_busy", 32'(cmd_ready), 32'd0);
         end
         if (poke && cyc == 45) cmd_valid = 1'b0;
         @(negedge clk);
         cyc++;
      end
      if (present && !rw) ref_mem[addr] = wdata;
      if (present && rw)  ref_rdata = ref_mem[addr];
      ref_stops++;
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("latency", 32'(cyc), 32'(exp_lat(rw, present)));
      chk("rsp_nack", 32'(rsp_nack), 32'(!present));
      chk("rdy_at_rsp", 32'(cmd_ready), 32'd0);
      chk("rsp_rdata", 32'(rsp_rdata), 32'(ref_rdata));
      chk("stop_seen", 32'(stop_cnt), 32'(ref_stops));
      if (present && rw)  chk("mnack_released", 32'(s_mack), 32'd1);
      if (present && !rw) chk("mem_written", 32'(slv_mem[addr]), 32'(ref_mem[addr]));
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rdata", 32'(rsp_rdata), 32'd0);
      chk("rst_nack", 32'(rsp_nack), 32'd0);
      chk("rst_dbg", 32'(dbg_dev), 32'(DEFDEV));
      chk("rst_scl", 32'(scl), 32'd1);
      chk("rst_sda", 32'(sda), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      run_cmd(1'b0, SLV_ID, 8'h10, 8'hA5, 1'b0);
      @(negedge clk);
      run_cmd(1'b1, SLV_ID, 8'h10, 8'h00, 1'b0);
      @(negedge clk);
      run_cmd(1'b1, SLV_ID, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      run_cmd(1'b0, 7'h23, 8'h44, 8'h99, 1'b0);
      mem_compare("absent_mem");

      // reset in the middle of the address byte of a write
      @(negedge clk);
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_dev = SLV_ID; cmd_addr = 8'h33; cmd_wdata = 8'h77;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (46 * CD + CD / 2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_scl", 32'(scl), 32'd1);
      chk("mid_rst_sda", 32'(sda), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
      chk("mid_rst_rdata", 32'(rsp_rdata), 32'd0);
      chk("mid_rst_dbg", 32'(dbg_dev), 32'(DEFDEV));
      ref_rdata = 8'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      ref_stops = stop_cnt;
      mem_compare("aborted_mem");
      run_cmd(1'b0, SLV_ID, 8'h33, 8'h77, 1'b0);

      // commands presented while busy are ignored; back-to-back issue
      @(negedge clk);
      run_cmd(1'b0, SLV_ID, 8'h20, 8'h3C, 1'b1);
      run_cmd(1'b1, SLV_ID, 8'h20, 8'h00, 1'b0);
      chk("b2b_gap", 32'(last_wait), 32'd1);
      mem_compare("poke_mem");

      for (int n = 0; n < 20; n++) begin
         int         op;
         logic [6:0] dev;
         logic [7:0] addr;
         op   = $urandom_range(0, 3);
         addr = 8'($urandom_range(0, 31));
         dev  = 7'($urandom_range(0, 127));
         if (dev == SLV_ID) dev = 7'h23;
         if ($urandom_range(0, 1) == 0) @(negedge clk);
         case (op)
            0, 1:    run_cmd(1'b0, SLV_ID, addr, 8'($urandom), 1'b0);
            2:       run_cmd(1'b1, SLV_ID, addr, 8'd0, 1'b0);
            default: run_cmd(1'b0, dev, addr, 8'($urandom), 1'b0);
         endcase
      end
      mem_compare("final_mem");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
